// File: rtl/seg7_scan_driver.sv
// Multiplexed active-low 7-segment scanner with brightness, blanking,
// leading-zero suppression and frame-synchronous double-buffered updates.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int DIV_BITS = 16,
    parameter int LZB      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   values,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    input  logic [2:0]            bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_tick,
    output logic                  upd_pending
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;

    logic [DIV_BITS-1:0] r_pre;
    logic [IW-1:0]       r_idx;
    logic [VW-1:0]       r_stg_val;
    logic [DIGITS-1:0]   r_stg_dp;
    logic [DIGITS-1:0]   r_stg_blank;
    logic [VW-1:0]       r_act_val;
    logic [DIGITS-1:0]   r_act_dp;
    logic [DIGITS-1:0]   r_act_blank;
    logic                r_pending;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_sel;
    logic                r_tick;

    logic                w_slot_end;
    logic                w_last;
    logic                w_frame_end;
    logic                w_on;
    logic [3:0]          w_nib;
    logic                w_dp_req;
    logic                w_blank;
    logic [6:0]          w_glyph;
    logic [DIGITS-1:0]   w_sel;

    function automatic logic [6:0] f_glyph(input logic [3:0] n);
        logic [6:0] g;
        unique case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign w_slot_end  = &r_pre;
    assign w_last      = (r_idx == IW'(DIGITS - 1));
    assign w_frame_end = w_slot_end && w_last;

    // pre == 0 is the guard cycle so the previous digit fully turns off
    assign w_on  = (r_pre != '0) && (r_pre[DIV_BITS-1 -: 3] <= bright);
    assign w_sel = ~(DIGITS'(w_on) << r_idx);

    always_comb begin : p_digit
        logic v_zero;
        v_zero   = 1'b1;
        w_nib    = 4'h0;
        w_dp_req = 1'b0;
        w_blank  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_zero = v_zero && (r_act_val[4*i +: 4] == 4'h0);
            if (r_idx == IW'(i)) begin
                w_nib    = r_act_val[4*i +: 4];
                w_dp_req = r_act_dp[i];
                w_blank  = r_act_blank[i] || ((LZB != 0) && (i > 0) && v_zero);
            end
        end
    end

    assign w_glyph = f_glyph(w_nib);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
            if (w_slot_end) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stg_val   <= '0;
            r_stg_dp    <= '0;
            r_stg_blank <= '0;
            r_act_val   <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (load) begin
                r_stg_val   <= values;
                r_stg_dp    <= dp_in;
                r_stg_blank <= blank_in;
            end
            // a load landing on the boundary bypasses staging
            if (w_frame_end && load) begin
                r_act_val   <= values;
                r_act_dp    <= dp_in;
                r_act_blank <= blank_in;
                r_pending   <= 1'b0;
            end else if (w_frame_end && r_pending) begin
                r_act_val   <= r_stg_val;
                r_act_dp    <= r_stg_dp;
                r_act_blank <= r_stg_blank;
                r_pending   <= 1'b0;
            end else if (load) begin
                r_pending   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg  <= 7'h7F;
            r_dp   <= 1'b1;
            r_sel  <= '1;
            r_tick <= 1'b0;
        end else begin
            r_sel  <= w_sel;
            r_tick <= w_frame_end;
            if (w_on && !w_blank) begin
                r_seg <= w_glyph;
                r_dp  <= ~w_dp_req;
            end else begin
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
            end
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign sel         = r_sel;
    assign frame_tick  = r_tick;
    assign upd_pending = r_pending;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multiplexed driver for a multi-digit common-select, active-low 7-segment display (Alchitry Io style).
- Decodes a packed hex word to glyphs, scans digits round-robin, and adds:
  - per-digit decimal point and blanking,
  - optional leading-zero suppression,
  - 8-level brightness,
  - tear-free double-buffered updates.
- Sits between user logic holding a display value and the board display pins.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- DIV_BITS, 16, prescaler width; each digit slot lasts 2^DIV_BITS clocks (minimum 4).
- LZB, 0, 1 = leading-zero blanking enabled.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- values  input  4*DIGITS  hex nibbles; nibble i = values[4i+3:4i]; digit 0 is least significant (rightmost).
- dp_in  input  DIGITS  decimal point request per digit, 1 = lit.
- blank_in  input  DIGITS  force digit dark, 1 = blank.
- load  input  1  capture values/dp_in/blank_in into staging.
- bright  input  3  brightness; 7 = max, 0 = min (never fully dark).
- seg  output  7  active-low segments; bit6 = g … bit0 = a.
- dp  output  1  active-low decimal point.
- sel  output  DIGITS  active-low digit select; sel[i] = 0 lights digit i.
- frame_tick  output  1  one-cycle pulse at each frame start.
- upd_pending  output  1  staging loaded, not yet applied.

Behaviour:
- Reset, asynchronous and effective immediately:
  - seg = 7'h7F, dp = 1, sel = all ones, frame_tick = 0, upd_pending = 0.
  - Prescaler = 0, digit index = 0, staging = 0, active = 0.
- Prescaler `pre` (DIV_BITS bits) increments every clock and wraps.
- Slot boundary = `pre` at all ones. At each slot boundary the digit index advances: idx = idx+1, or 0 when idx = DIGITS-1.
- Frame boundary = slot boundary with idx = DIGITS-1.
- Double buffer:
  - load = 1 captures inputs into staging and sets upd_pending.
  - At a frame boundary with upd_pending = 1, active <= staging and upd_pending clears.
  - If load coincides with a frame boundary, active and staging both take the current inputs directly and upd_pending = 0.
  - Repeated loads before the boundary: the last one wins.
- Glyph table, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blanking of digit i, evaluated on active data:
  - Blanked if active blank[i] = 1.
  - When LZB = 1, also blanked if i > 0 and active nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never suppressed by LZB.
  - A blanked digit has seg = 7'h7F and dp = 1.
  - Its sel is still asserted in the on-window (harmless, keeps timing uniform).
- On-window for the current slot:
  - on = (pre != 0) && (pre[DIV_BITS-1:DIV_BITS-3] <= bright).
  - `pre` = 0 is the anti-ghost guard cycle: all sel high.
- Outputs are registered with 1-cycle latency from the `pre`/idx state:
  - sel = ~(on << idx) masked to DIGITS bits.
  - seg = glyph or 7'h7F.
  - dp = ~(active dp[idx]) when on and not blanked, else 1.
  - When not on: seg = 7'h7F, dp = 1.
- frame_tick is registered: high on the cycle after the frame boundary edge.
- At most one sel bit is low at any time.
- Reset mid-frame returns all outputs to dark on the same edge; scanning restarts at digit 0.

Test Plan:
- DIGITS=4, DIV_BITS=4, bright=7, load values=16'h12AF then wait 1 frame:
  - Digit 0 shows 0001110, digit 1 shows 0001000, digit 2 shows 0100100, digit 3 shows 1111001.
  - Each sel low for exactly 15 of 16 cycles, with the guard cycle high.
- bright=0, DIV_BITS=4: each sel low only for pre = 1 (1 cycle per slot). bright=3: sel low for pre = 1..7 (7 cycles).
- LZB=1, load 16'h0050:
  - Digits 3 and 2 dark (seg=7F), digit 1 = 0010010, digit 0 = 1000000.
  - Load 16'h0000: only digit 0 lit, showing 1000000.
- Load 16'h1111 mid-frame:
  - upd_pending = 1, display unchanged until the frame boundary.
  - Then new glyphs appear, upd_pending = 0, and frame_tick pulses once.
- dp_in=4'b0100, blank_in=4'b0001: dp low only during digit 2 on-window; digit 0 seg=7F and dp=1 throughout.
- Assert rst for 1 cycle mid-slot: seg=7F, sel=F immediately (asynchronous); after release the first lit digit is digit 0 with active data 0, i.e. 1000000 on digit 0 (a plain reset does not restore the old value).
